axi4_lite_reg_slave: RTL
========================

Name: axi4_lite_reg_slave

Overview:
- AXI4-Lite responder (slave end of the team's AXI4-Lite bus) that exposes a bank of read-write control registers and read-only status registers to a bus master.
- Sits behind an interconnect port. RW register contents drive fabric logic directly; RO registers are sampled from fabric inputs.
- Write and read channels are fully independent. Each channel has at most one outstanding transaction.

Parameters:
- ADDR_W, 32, address width of the AXI4-Lite port.
- DATA_W, 32, data width; legal values are 32 and 64.
- RW_COUNT, 8, number of read-write registers; must be at least 1.
- RO_COUNT, 8, number of read-only registers; may be 0.

Ports:
- ACLK  in  1  bus clock; all logic is on its rising edge.
- ARESETn  in  1  reset, asynchronous assert, active-low.
- AWVALID/AWREADY  in/out  1/1  write-address handshake.
- AWADDR  in  ADDR_W  write byte address.
- AWPROT  in  3  ignored.
- WVALID/WREADY  in/out  1/1  write-data handshake.
- WDATA  in  DATA_W  write data.
- WSTRB  in  DATA_W/8  byte enables.
- BVALID/BREADY  out/in  1/1  write-response handshake.
- BRESP  out  1  0 = OKAY, 1 = SLVERR.
- ARVALID/ARREADY  in/out  1/1  read-address handshake.
- ARADDR  in  ADDR_W  read byte address.
- ARPROT  in  3  ignored.
- RVALID/RREADY  out/in  1/1  read-data handshake.
- RDATA  out  DATA_W  read data.
- RRESP  out  1  0 = OKAY, 1 = SLVERR.
- rw_regs  out  RW_COUNT*DATA_W  RW register contents; register i occupies bits [i*DATA_W +: DATA_W].
- wr_pulse  out  RW_COUNT  one-cycle strobe on the cycle after register i is written.
- ro_regs  in  RO_COUNT*DATA_W  status values, packed the same way as rw_regs.

Behaviour:
- Reset (ARESETn low, asynchronous):
  - AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, wr_pulse = 0.
  - RDATA = 0; all rw_regs = 0.
  - The READY outputs go to 1 on the first ACLK edge after ARESETn is released.
- Address decode:
  - Index = ADDR >> log2(DATA_W/8); the low byte-offset bits are ignored.
  - Index 0..RW_COUNT-1 selects an RW register.
  - Index RW_COUNT..RW_COUNT+RO_COUNT-1 selects an RO register.
  - Any other index is out of range.
- Write channel:
  - Internal flags aw_held and w_held capture AWADDR and WDATA/WSTRB independently.
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
  - AW and W may complete in either order or in the same cycle.
  - Commit happens on the edge ending the cycle in which the later of the two handshakes completes; the commit mux uses held or live values as needed.
  - On commit:
    - If the index is an RW register, update byte k only where WSTRB[k]=1, set BRESP=0, and pulse wr_pulse[index] for exactly one cycle. The pulse is asserted even if WSTRB=0.
    - If the index is an RO register, no update, BRESP=0 (write silently ignored).
    - If the index is out of range, no update, BRESP=1.
  - BVALID goes high on the same edge as the commit and both held flags clear.
  - BVALID and BRESP stay stable until the BREADY handshake.
  - AWREADY and WREADY reassert on the edge that completes the B handshake.
  - Minimum throughput is one write per 2 cycles.
- Read channel:
  - ARREADY = !RVALID.
  - On the AR handshake, the next edge loads RDATA with the selected register, sets RRESP (0 in range, 1 out of range, with RDATA=0), and sets RVALID=1.
  - RVALID, RDATA and RRESP stay stable until the RREADY handshake.
  - ARREADY reasserts on the edge that completes the R handshake.
  - ro_regs is sampled at the AR handshake; later changes do not alter a pending RDATA.
- Simultaneous events:
  - A read and a write to the same RW register committing on the same edge: the read returns the pre-write value.
  - BREADY or RREADY held high before valid: the handshake completes in the first cycle valid is high.
- Mid-operation reset: all pending transactions and held flags are discarded, and the outputs take their reset values immediately.
- Handshake rule: no READY output depends combinationally on the same-cycle VALID.

Test Plan:
- Reset then idle -> AWREADY=WREADY=ARREADY=1 one cycle after ARESETn rises; BVALID=RVALID=0; rw_regs all 0.
- Write 0xDEADBEEF to 0x04 with WSTRB=0xF, AW and W in the same cycle, BREADY=1 -> BVALID next cycle with BRESP=0; rw_regs[1]=0xDEADBEEF; wr_pulse[1] high for exactly 1 cycle.
- W issued 3 cycles before AW, WSTRB=0x3, WDATA=0x11223344, target reg 1 -> WREADY drops after W accepted; rw_regs[1]=0xDEAD3344 after AW arrives; B returned one cycle after AW.
- Read 0x20 (RO reg 0) with ro_regs[0]=0xCAFE0001 and RREADY held low for 4 cycles -> RVALID high and RDATA=0xCAFE0001, RRESP=0 stable all 4 cycles; ARREADY=0 until the R handshake.
- Write then read 0x100 (out of range, defaults) -> BRESP=1 and no rw_regs change; RRESP=1 with RDATA=0.
- Assert ARESETn low while BVALID=1 and a read is pending -> BVALID=RVALID=0 immediately; rw_regs=0; normal writes succeed after release.

Source files
------------

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite responder exposing RW control registers and RO status registers.
// Write and read channels are independent, each with at most one transaction in flight.
module axi4_lite_reg_slave #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RW_COUNT = 8,
  parameter int RO_COUNT = 8
) (
  input  logic                                             ACLK,
  input  logic                                             ARESETn,
  input  logic                                             AWVALID,
  output logic                                             AWREADY,
  input  logic [ADDR_W-1:0]                                AWADDR,
  input  logic [2:0]                                       AWPROT,
  input  logic                                             WVALID,
  output logic                                             WREADY,
  input  logic [DATA_W-1:0]                                WDATA,
  input  logic [DATA_W/8-1:0]                              WSTRB,
  output logic                                             BVALID,
  input  logic                                             BREADY,
  output logic                                             BRESP,
  input  logic                                             ARVALID,
  output logic                                             ARREADY,
  input  logic [ADDR_W-1:0]                                ARADDR,
  input  logic [2:0]                                       ARPROT,
  output logic                                             RVALID,
  input  logic                                             RREADY,
  output logic [DATA_W-1:0]                                RDATA,
  output logic                                             RRESP,
  output logic [RW_COUNT*DATA_W-1:0]                       rw_regs,
  output logic [RW_COUNT-1:0]                              wr_pulse,
  input  logic [((RO_COUNT > 0) ? RO_COUNT : 1)*DATA_W-1:0] ro_regs
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam logic [ADDR_W-1:0] RW_END = ADDR_W'(RW_COUNT);
  localparam logic [ADDR_W-1:0] RO_END = ADDR_W'(RW_COUNT + RO_COUNT);

  logic                       rdy_en_q, rdy_en_d;
  logic                       aw_held_q, aw_held_d;
  logic [ADDR_W-1:0]          awaddr_q, awaddr_d;
  logic                       w_held_q, w_held_d;
  logic [DATA_W-1:0]          wdata_q, wdata_d;
  logic [STRB_W-1:0]          wstrb_q, wstrb_d;
  logic                       bvalid_q, bvalid_d;
  logic                       bresp_q, bresp_d;
  logic [RW_COUNT*DATA_W-1:0] rw_q, rw_d;
  logic [RW_COUNT-1:0]        wr_pulse_q, wr_pulse_d;
  logic                       rvalid_q, rvalid_d;
  logic                       rresp_q, rresp_d;
  logic [DATA_W-1:0]          rdata_q, rdata_d;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_W-1:0] wr_addr, wr_idx, rd_idx;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              unused_ok;

  assign unused_ok = ^{AWPROT, ARPROT};

  // rdy_en keeps all READYs low through reset and for the first edge after it.
  assign rdy_en_d = 1'b1;
  assign AWREADY  = rdy_en_q && !aw_held_q && !bvalid_q;
  assign WREADY   = rdy_en_q && !w_held_q && !bvalid_q;
  assign ARREADY  = rdy_en_q && !rvalid_q;
  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign RVALID   = rvalid_q;
  assign RRESP    = rresp_q;
  assign RDATA    = rdata_q;
  assign rw_regs  = rw_q;
  assign wr_pulse = wr_pulse_q;

  always_comb begin
    aw_hs   = AWVALID && AWREADY;
    w_hs    = WVALID && WREADY;
    wr_addr = aw_held_q ? awaddr_q : AWADDR;
    wr_data = w_held_q ? wdata_q : WDATA;
    wr_strb = w_held_q ? wstrb_q : WSTRB;
    wr_idx  = wr_addr >> OFF_W;
    commit  = (aw_hs || aw_held_q) && (w_hs || w_held_q);

    aw_held_d  = aw_held_q;
    awaddr_d   = awaddr_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rw_d       = rw_q;
    wr_pulse_d = '0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = AWADDR;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = WDATA;
      wstrb_d  = WSTRB;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (wr_idx >= RO_END);
      for (int i = 0; i < RW_COUNT; i++) begin
        if (wr_idx == ADDR_W'(i)) begin
          wr_pulse_d[i] = 1'b1;
          for (int k = 0; k < STRB_W; k++) begin
            if (wr_strb[k]) rw_d[i*DATA_W + k*8 +: 8] = wr_data[k*8 +: 8];
          end
        end
      end
    end else if (bvalid_q && BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  // Reads sample rw_q, so a same-edge write is not visible to the read.
  always_comb begin
    ar_hs    = ARVALID && ARREADY;
    rd_idx   = ARADDR >> OFF_W;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = (rd_idx >= RO_END);
      rdata_d  = '0;
      if (rd_idx < RW_END) begin
        for (int i = 0; i < RW_COUNT; i++) begin
          if (rd_idx == ADDR_W'(i)) rdata_d = rw_q[i*DATA_W +: DATA_W];
        end
      end else begin
        for (int j = 0; j < RO_COUNT; j++) begin
          if (rd_idx == ADDR_W'(RW_COUNT + j)) rdata_d = ro_regs[j*DATA_W +: DATA_W];
        end
      end
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rdy_en_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 1'b0;
      rw_q       <= '0;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rdy_en_q   <= rdy_en_d;
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rw_q       <= rw_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule
